// File: rtl/disp_cmd_pkg.sv
// Shared definitions for the display command sequencer.
//   - opcode constants for the byte command stream
//   - fetch FSM states and parser phases
//   - reset attribute, blank character and the 16-bit text cell layout
package disp_cmd_pkg;

    localparam logic [7:0] OP_SET_ROW  = 8'h01;
    localparam logic [7:0] OP_SET_COL  = 8'h02;
    localparam logic [7:0] OP_SET_ATTR = 8'h03;
    localparam logic [7:0] OP_PUT_CHAR = 8'h04;
    localparam logic [7:0] OP_CLEAR    = 8'h05;

    localparam logic [7:0] ATTR_RESET  = 8'h0F;
    localparam logic [7:0] BLANK_CHAR  = 8'h20;

    typedef enum logic [1:0] {IDLE, STROBE, RECOV, FILL} fetch_state_e;
    typedef enum logic {PH_OPC, PH_ARG} parse_phase_e;

    typedef struct packed {
        logic [7:0] attr;
        logic [7:0] ch;
    } cell_t;

endpackage

// File: rtl/fifo_rd_if.sv
// External FIFO read interface.
// Synchronises the asynchronous active-low empty flag, generates the
// active-low read strobe (RD_WAIT cycles low, then 3 recovery cycles high)
// and latches the FIFO byte in the last strobe cycle.
// Ports:
//   clk, rst       clock, async active-high reset
//   disp_cmd_in    FIFO data, sampled only at the latch point
//   nef_in         FIFO not-empty flag (async to clk)
//   hold           blocks new reads; parks the FSM in FILL after recovery
//   disp_cmd_rd    read strobe, active-low, registered
//   byte_valid     one-cycle pulse in the first recovery cycle
//   byte_q         latched byte, valid with byte_valid
//   recov_done     high in the last recovery cycle
module fifo_rd_if
    import disp_cmd_pkg::*;
#(
    parameter int RD_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] disp_cmd_in,
    input  logic       nef_in,
    input  logic       hold,
    output logic       disp_cmd_rd,
    output logic       byte_valid,
    output logic [7:0] byte_q,
    output logic       recov_done
);

    localparam int CNT_MAX = (RD_WAIT > 3) ? RD_WAIT : 3;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(2);

    fetch_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_d;
    logic             vld_q, vld_d;
    logic             rd_q, rd_d;
    logic             nef_m_q, nef_s_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        vld_d      = 1'b0;
        recov_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (nef_s_q && !hold) begin
                    state_d = STROBE;
                    cnt_d   = '0;
                end
            end
            STROBE: begin
                if (cnt_q == STB_LAST) begin
                    byte_d  = disp_cmd_in;
                    vld_d   = 1'b1;
                    state_d = RECOV;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RECOV: begin
                if (cnt_q == REC_LAST) begin
                    recov_done = 1'b1;
                    cnt_d      = '0;
                    // By now the synchroniser reflects the post-read flag, so a
                    // back-to-back read can start without an IDLE cycle.
                    if (hold)         state_d = FILL;
                    else if (nef_s_q) state_d = STROBE;
                    else              state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FILL: begin
                if (!hold) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Strobe comes straight from a flop so it cannot glitch on state decode.
        rd_d = (state_d != STROBE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            byte_q  <= '0;
            vld_q   <= 1'b0;
            rd_q    <= 1'b1;
            nef_m_q <= 1'b0;
            nef_s_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            vld_q   <= vld_d;
            rd_q    <= rd_d;
            nef_m_q <= nef_in;
            nef_s_q <= nef_m_q;
        end
    end

    assign disp_cmd_rd = rd_q;
    assign byte_valid  = vld_q;

endmodule

// File: rtl/disp_cmd_ctrl.sv
// Display command sequencer: drains the command FIFO, parses the byte
// command stream, tracks cursor/attribute and writes text cells.
// Optional feature macro: DISP_CMD_CLEAR_EN (enables opcode 0x05 screen fill).
// Ports:
//   clk, rst      clock, async active-high reset
//   disp_cmd_in   FIFO data
//   nef_in        FIFO not-empty flag, async
//   disp_cmd_rd   FIFO read strobe, active-low
//   mem_we        cell write enable, single-cycle pulse
//   mem_addr      cell address row*COLS+col
//   mem_wdata     {attr, char}
//   busy          high during a clear fill
module disp_cmd_ctrl
    import disp_cmd_pkg::*;
#(
    parameter int COLS    = 80,
    parameter int ROWS    = 30,
    parameter int ADDR_W  = 12,
    parameter int RD_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        disp_cmd_in,
    input  logic              nef_in,
    output logic              disp_cmd_rd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy
);

    localparam int CELLS = ROWS * COLS;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ADDR_W-1:0] LAST_LIN = ADDR_W'(CELLS - 1);

    logic       byte_valid, recov_done, hold;
    logic [7:0] byte_q;

    fifo_rd_if #(.RD_WAIT(RD_WAIT)) u_rd (
        .clk         (clk),
        .rst         (rst),
        .disp_cmd_in (disp_cmd_in),
        .nef_in      (nef_in),
        .hold        (hold),
        .disp_cmd_rd (disp_cmd_rd),
        .byte_valid  (byte_valid),
        .byte_q      (byte_q),
        .recov_done  (recov_done)
    );

    parse_phase_e      phase_q, phase_d;
    logic [7:0]        opc_q, opc_d, attr_q, attr_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [ADDR_W-1:0] lin_q, lin_d;
    logic              recalc_q, recalc_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    cell_t             mem_wdata_q, mem_wdata_d;

`ifdef DISP_CMD_CLEAR_EN
    localparam int FW = ADDR_W + 1;
    localparam logic [FW-1:0] FILL_END = FW'(CELLS);
    logic          fill_pend_q, fill_pend_d, busy_q, busy_d;
    logic [FW-1:0] fill_cnt_q, fill_cnt_d;
    assign hold = fill_pend_q | busy_q;
    assign busy = busy_q;
`else
    logic unused_recov;
    assign unused_recov = recov_done;
    assign hold = 1'b0;
    assign busy = 1'b0;
`endif

    always_comb begin
        phase_d     = phase_q;
        opc_d       = opc_q;
        attr_d      = attr_q;
        row_d       = row_q;
        col_d       = col_q;
        lin_d       = lin_q;
        recalc_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef DISP_CMD_CLEAR_EN
        fill_pend_d = fill_pend_q;
        busy_d      = busy_q;
        fill_cnt_d  = fill_cnt_q;
`endif
        // Linear address is rebuilt the cycle after an explicit row/col set;
        // the next command byte is always several cycles away.
        if (recalc_q) lin_d = ADDR_W'(32'(row_q) * COLS + 32'(col_q));

        if (byte_valid) begin
            if (phase_q == PH_OPC) begin
                case (byte_q)
                    OP_SET_ROW, OP_SET_COL, OP_SET_ATTR, OP_PUT_CHAR: begin
                        phase_d = PH_ARG;
                        opc_d   = byte_q;
                    end
`ifdef DISP_CMD_CLEAR_EN
                    OP_CLEAR: fill_pend_d = 1'b1;
`endif
                    default: ;
                endcase
            end else begin
                phase_d = PH_OPC;
                case (opc_q)
                    OP_SET_ROW: if (32'(byte_q) < ROWS) begin
                        row_d    = RW'(byte_q);
                        recalc_d = 1'b1;
                    end
                    OP_SET_COL: if (32'(byte_q) < COLS) begin
                        col_d    = CW'(byte_q);
                        recalc_d = 1'b1;
                    end
                    OP_SET_ATTR: attr_d = byte_q;
                    OP_PUT_CHAR: begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = lin_q;
                        mem_wdata_d = '{attr: attr_q, ch: byte_q};
                        if (lin_q == LAST_LIN) begin
                            row_d = '0;
                            col_d = '0;
                            lin_d = '0;
                        end else if (col_q == CW'(COLS - 1)) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                            lin_d = lin_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                            lin_d = lin_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

`ifdef DISP_CMD_CLEAR_EN
        // Fill starts from the last recovery cycle so that the first write
        // lands in the cycle right after recovery.
        if (recov_done && fill_pend_q) begin
            fill_pend_d = 1'b0;
            busy_d      = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = '0;
            mem_wdata_d = '{attr: attr_q, ch: BLANK_CHAR};
            fill_cnt_d  = FW'(1);
        end else if (busy_q) begin
            if (fill_cnt_q < FILL_END) begin
                mem_we_d   = 1'b1;
                mem_addr_d = fill_cnt_q[ADDR_W-1:0];
                fill_cnt_d = fill_cnt_q + 1'b1;
            end else begin
                busy_d = 1'b0;
                row_d  = '0;
                col_d  = '0;
                lin_d  = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= PH_OPC;
            opc_q       <= '0;
            attr_q      <= ATTR_RESET;
            row_q       <= '0;
            col_q       <= '0;
            lin_q       <= '0;
            recalc_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            phase_q     <= phase_d;
            opc_q       <= opc_d;
            attr_q      <= attr_d;
            row_q       <= row_d;
            col_q       <= col_d;
            lin_q       <= lin_d;
            recalc_q    <= recalc_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef DISP_CMD_CLEAR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            fill_cnt_q  <= '0;
        end else begin
            fill_pend_q <= fill_pend_d;
            busy_q      <= busy_d;
            fill_cnt_q  <= fill_cnt_d;
        end
    end
`endif

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_disp_cmd_ctrl.sv
// Self-checking bench for disp_cmd_ctrl: FIFO model driving the DUT, a
// cursor/attribute reference model producing the expected cell writes,
// directed cases followed by a randomized command stream.
module tb_disp_cmd_ctrl;

    localparam int COLS = 80, ROWS = 30, ADDR_W = 12, RD_WAIT = 2;
    localparam int CELLS = COLS * ROWS;
`ifdef DISP_CMD_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        disp_cmd_in = 8'h00;
    logic              nef_in = 1'b0;
    logic              disp_cmd_rd, mem_we, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    disp_cmd_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .rst(rst), .disp_cmd_in(disp_cmd_in), .nef_in(nef_in),
        .disp_cmd_rd(disp_cmd_rd), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int addr; int data; int cyc; int lat; bit bsy;} wr_t;
    typedef struct {int addr; int data; int kind;} ew_t; // kind: 0 put, 1 first fill, 2 fill

    wr_t wr_q[$];
    ew_t exp_q[$];
    int  fifo[$];
    int  strobe_lens[$];
    int  cyc = 0, last_rise = 0, strobe_len = 0, busy_cycles = 0, strobe_in_busy = 0;
    bit  rd_prev = 1'b1;
    int  n_chk = 0, n_fail = 0, n_sent = 0;
    int  m_row, m_col, m_attr, m_phase, m_opc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // FIFO model and output monitor, both sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            rd_prev    = 1'b1;
            strobe_len = 0;
        end else begin
            if (!disp_cmd_rd) strobe_len++;
            if (disp_cmd_rd && !rd_prev) begin
                strobe_lens.push_back(strobe_len);
                strobe_len = 0;
                last_rise  = cyc;
                if (fifo.size() != 0) void'(fifo.pop_front());
            end
            if (!disp_cmd_rd && busy) strobe_in_busy++;
            if (busy) busy_cycles++;
            if (mem_we) wr_q.push_back('{int'(mem_addr), int'(mem_wdata), cyc, cyc - last_rise, busy});
            rd_prev = disp_cmd_rd;
        end
        nef_in      = (fifo.size() != 0);
        disp_cmd_in = (fifo.size() != 0) ? 8'(fifo[0]) : 8'h00;
    end

    task automatic model_reset();
        m_row = 0; m_col = 0; m_attr = 8'h0F; m_phase = 0; m_opc = 0;
    endtask

    task automatic model_byte(input int b);
        int lin;
        if (m_phase == 0) begin
            if (b >= 1 && b <= 4) begin
                m_phase = 1;
                m_opc   = b;
            end else if (b == 5 && CLEAR_EN) begin
                for (int a = 0; a < CELLS; a++)
                    exp_q.push_back('{a, m_attr * 256 + 32, (a == 0) ? 1 : 2});
                m_row = 0; m_col = 0;
            end
        end else begin
            m_phase = 0;
            case (m_opc)
                1: if (b < ROWS) m_row = b;
                2: if (b < COLS) m_col = b;
                3: m_attr = b;
                4: begin
                    lin = m_row * COLS + m_col;
                    exp_q.push_back('{lin, m_attr * 256 + b, 0});
                    lin   = (lin + 1) % CELLS;
                    m_row = lin / COLS;
                    m_col = lin % COLS;
                end
                default: ;
            endcase
        end
    endtask

    task automatic send(input int b);
        fifo.push_back(b);
        model_byte(b);
        n_sent++;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (fifo.size() != 0 && t < 20000) begin @(negedge clk); t++; end
        chk("drain_fifo", fifo.size(), 0);
        repeat (12) @(negedge clk);
        t = 0;
        while (busy !== 1'b0 && t < 5000) begin @(negedge clk); t++; end
        chk("drain_busy", busy, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        int prev_cyc, n_fill;
        prev_cyc = 0;
        n_fill   = 0;
        chk({tag, "_nwr"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            chk({tag, "_addr"}, wr_q[i].addr, exp_q[i].addr);
            chk({tag, "_data"}, wr_q[i].data, exp_q[i].data);
            case (exp_q[i].kind)
                0: begin
                    chk({tag, "_put_lat"}, wr_q[i].lat, 1);
                    chk({tag, "_put_busy"}, wr_q[i].bsy, 0);
                end
                1: begin
                    chk({tag, "_fill_lat"}, wr_q[i].lat, 3);
                    chk({tag, "_fill_busy"}, wr_q[i].bsy, 1);
                    n_fill++;
                end
                default: begin
                    chk({tag, "_fill_consec"}, wr_q[i].cyc, prev_cyc + 1);
                    chk({tag, "_fill_busy"}, wr_q[i].bsy, 1);
                    n_fill++;
                end
            endcase
            prev_cyc = wr_q[i].cyc;
        end
        chk({tag, "_nstrobe"}, strobe_lens.size(), n_sent);
        foreach (strobe_lens[i]) chk({tag, "_strobe_len"}, strobe_lens[i], RD_WAIT);
        chk({tag, "_busy_cycles"}, busy_cycles, n_fill);
        chk({tag, "_strobe_in_busy"}, strobe_in_busy, 0);
        wr_q.delete(); exp_q.delete(); strobe_lens.delete();
        n_sent = 0; busy_cycles = 0; strobe_in_busy = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd"}, disp_cmd_rd, 1);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, op, arg;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst0");
        rst = 1'b0;

        // single PUT_CHAR with defaults
        send(8'h04); send(8'h41);
        drain();
        chk("t1_nwr", wr_q.size(), 1);
        if (wr_q.size() > 0) begin
            chk("t1_addr_c", wr_q[0].addr, 0);
            chk("t1_data_c", wr_q[0].data, 16'h0F41);
        end
        check_all("t1");

        // last cell and wrap to (0,0)
        send(8'h01); send(8'h1D); send(8'h02); send(8'h4F);
        send(8'h04); send(8'h58); send(8'h04); send(8'h59);
        drain();
        chk("t2_nwr", wr_q.size(), 2);
        if (wr_q.size() > 1) begin
            chk("t2_addr0_c", wr_q[0].addr, 2399);
            chk("t2_data0_c", wr_q[0].data, 16'h0F58);
            chk("t2_addr1_c", wr_q[1].addr, 0);
            chk("t2_data1_c", wr_q[1].data, 16'h0F59);
        end
        check_all("t2");

        // attribute, out-of-range row ignored
        send(8'h01); send(8'h00); send(8'h02); send(8'h00);
        send(8'h03); send(8'h1E); send(8'h01); send(8'h22); send(8'h04); send(8'h5A);
        drain();
        if (wr_q.size() > 0) begin
            chk("t3_addr_c", wr_q[0].addr, 0);
            chk("t3_data_c", wr_q[0].data, 16'h1E5A);
        end
        check_all("t3");

        // empty FIFO: no strobe, no write
        repeat (100) @(negedge clk);
        chk("idle_rd", disp_cmd_rd, 1);
        check_all("idle");

        // FIFO empties between opcode and operand: parser waits in ARG
        send(8'h04);
        repeat (50) @(negedge clk);
        chk("hold_nowr", wr_q.size(), 0);
        send(8'h44);
        drain();
        if (wr_q.size() > 0) chk("hold_addr_c", wr_q[0].addr, 1);
        check_all("hold");

        // reset asserted in the middle of a strobe
        send(8'h03); send(8'h77);
        drain();
        check_all("pre_rst");
        send(8'h04); send(8'h41);
        t = 0;
        while (disp_cmd_rd === 1'b1 && t < 200) begin @(negedge clk); t++; end
        chk("rst_strobe_seen", disp_cmd_rd, 0);
        #1 rst = 1'b1;
        #1 chk("rst_async_rd", disp_cmd_rd, 1);
        fifo.delete(); wr_q.delete(); exp_q.delete(); strobe_lens.delete();
        n_sent = 0; busy_cycles = 0; strobe_in_busy = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst1");
        rst = 1'b0;
        send(8'h04); send(8'h42);
        drain();
        if (wr_q.size() > 0) begin
            chk("rst_addr_c", wr_q[0].addr, 0);
            chk("rst_data_c", wr_q[0].data, 16'h0F42);
        end
        check_all("rst");

        // CLEAR with further bytes already waiting in the FIFO
        send(8'h05); send(8'h04); send(8'h43);
        drain();
        if (wr_q.size() > 0) chk("clr_put_addr_c", wr_q[wr_q.size()-1].addr, CLEAR_EN ? 0 : 1);
        check_all("clr");

        // randomized command stream with random FIFO gaps
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0: begin op = 1; arg = ($urandom_range(0, 3) == 0) ? ROWS - 1 : int'($urandom_range(0, 40)); end
                1: begin op = 2; arg = ($urandom_range(0, 3) == 0) ? COLS - 2 : int'($urandom_range(0, 100)); end
                2: begin op = 3; arg = int'($urandom_range(0, 255)); end
                7: begin op = int'($urandom_range(6, 255)); arg = -1; end
                8: begin op = 0; arg = -1; end
                default: begin op = 4; arg = int'($urandom_range(0, 255)); end
            endcase
            send(op);
            if (arg >= 0) begin
                repeat ($urandom_range(0, 8)) @(negedge clk);
                send(arg);
            end
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        drain();
        check_all("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
